lea_full_adder: RTL and testbench



---
 rtl/lea_full_adder.sv | 64 ++++++
 tb/tb_lea_full_adder.sv | 134 +++++++++++++
 2 files changed

// File: rtl/lea_full_adder.sv
// lea_full_adder: registered ripple-carry adder cell with sum, carry-out and signed overflow.
//   Ports: clk, rst (sync, active-high), A/B [WIDTH-1:0] operands, Cin carry into bit 0,
//          S [WIDTH-1:0] registered sum, Cout registered carry out of MSB,
//          Ovf registered signed overflow (carry into MSB ^ carry out of MSB).
//   Option: define LEA_FA_PIPE2_EN to add a resettable input register stage (latency 2).
module lea_full_adder #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf
);
    logic [WIDTH-1:0] w_a, w_b, w_s;
    logic             w_cin;
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] r_s;
    logic             r_cout, r_ovf;
`ifdef LEA_FA_PIPE2_EN
    logic [WIDTH-1:0] r_a, r_b;
    logic             r_cin;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_cin <= 1'b0;
        end else begin
            r_a   <= A;
            r_b   <= B;
            r_cin <= Cin;
        end
    end
    assign w_a   = r_a;
    assign w_b   = r_b;
    assign w_cin = r_cin;
`else
    assign w_a   = A;
    assign w_b   = B;
    assign w_cin = Cin;
`endif
    assign w_c[0] = w_cin;
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign w_s[i]   = w_a[i] ^ w_b[i] ^ w_c[i];
        assign w_c[i+1] = (w_a[i] & w_b[i]) | (w_c[i] & (w_a[i] ^ w_b[i]));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s    <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_s    <= w_s;
            r_cout <= w_c[WIDTH];
            r_ovf  <= w_c[WIDTH] ^ w_c[WIDTH-1];
        end
    end
    assign S    = r_s;
    assign Cout = r_cout;
    assign Ovf  = r_ovf;
endmodule

// File: tb/tb_lea_full_adder.sv
// tb_lea_full_adder: scoreboard bench for 1-bit and 8-bit adder instances against an arithmetic model.
module tb_lea_full_adder;
`ifdef LEA_FA_PIPE2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    typedef struct {
        bit       rst;
        bit [2:0] e1;
        bit [9:0] e8;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       a1, b1, c1, c8;
    logic [7:0] a8, b8;
    logic       s1, co1, ov1, co8, ov8;
    logic [7:0] s8;
    int         tests = 0;
    int         fails = 0;
    exp_t       q[$];

    always #5 clk = ~clk;

    lea_full_adder #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .A(a1), .B(b1), .Cin(c1),
        .S(s1), .Cout(co1), .Ovf(ov1)
    );
    lea_full_adder #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .A(a8), .B(b8), .Cin(c8),
        .S(s8), .Cout(co8), .Ovf(ov8)
    );

    // {ovf, cout, sum} from plain integer arithmetic: unsigned sum plus signed range test
    function automatic int model(int w, int a, int b, int c);
        int half = 1 << (w - 1);
        int sa   = (a >= half) ? a - (1 << w) : a;
        int sb   = (b >= half) ? b - (1 << w) : b;
        int ss   = sa + sb + c;
        int ovf  = (ss > half - 1 || ss < -half) ? 1 : 0;
        return (ovf << (w + 1)) | (a + b + c);
    endfunction

    task automatic step(input bit r, input bit xa1, input bit xb1, input bit xc1,
                        input bit [7:0] xa8, input bit [7:0] xb8, input bit xc8);
        exp_t e;
        rst = r; a1 = xa1; b1 = xb1; c1 = xc1; a8 = xa8; b8 = xb8; c8 = xc8;
        e.rst = r;
        e.e1  = 3'(model(1, int'(xa1), int'(xb1), int'(xc1)));
        e.e8  = 10'(model(8, int'(xa8), int'(xb8), int'(xc8)));
        @(posedge clk);
        q.push_back(e);
        #1;
    endtask

    task automatic step1(input bit r, input bit xa, input bit xb, input bit xc);
        step(r, xa, xb, xc, 8'h00, 8'h00, 1'b0);
    endtask

    // Monitor: every edge yields an output; expectation is the entry LAT-1 edges back, zeroed by any reset in between
    initial begin
        exp_t cur, prev;
        bit [2:0] x1;
        bit [9:0] x8;
        prev.rst = 1'b1; prev.e1 = '0; prev.e8 = '0;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                cur = q.pop_front();
                if (cur.rst || (LAT == 2 && prev.rst)) begin
                    x1 = '0;
                    x8 = '0;
                end else begin
                    x1 = (LAT == 1) ? cur.e1 : prev.e1;
                    x8 = (LAT == 1) ? cur.e8 : prev.e8;
                end
                prev = cur;
                tests++;
                if ({ov1, co1, s1} !== x1) begin
                    fails++;
                    $display("FAIL w1 {Ovf,Cout,S} got %b want %b at %0t", {ov1, co1, s1}, x1, $time);
                end
                tests++;
                if ({ov8, co8, s8} !== x8) begin
                    fails++;
                    $display("FAIL w8 {Ovf,Cout,S} got %b want %b at %0t", {ov8, co8, s8}, x8, $time);
                end
            end
        end
    end

    initial begin
        // reset with all-ones operands held, then release
        step1(1, 1, 1, 1);
        step1(1, 1, 1, 1);
        step1(0, 1, 1, 1);
        step1(0, 0, 0, 0);
        step1(0, 0, 0, 0);
        // exhaustive 1-bit
        for (int k = 0; k < 8; k++) step1(0, k[2], k[1], k[0]);
        // mid-stream reset swallowing 1+1+0
        step1(0, 0, 0, 0);
        step1(1, 1, 1, 0);
        step1(0, 0, 0, 0);
        step1(0, 0, 0, 0);
        // sparse pulses
        step1(0, 1, 0, 0);
        step1(0, 0, 0, 0);
        step1(0, 0, 1, 1);
        step1(0, 0, 0, 0);
        step1(0, 0, 0, 0);
        // 8-bit corner vectors
        step(0, 0, 0, 0, 8'hFF, 8'h01, 1'b0);
        step(0, 0, 0, 0, 8'h7F, 8'h00, 1'b1);
        step(0, 0, 0, 0, 8'h80, 8'h80, 1'b0);
        step(0, 0, 0, 0, 8'hFF, 8'hFF, 1'b1);
        // random traffic with occasional reset
        for (int k = 0; k < 200; k++)
            step(($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
                 8'($urandom), 8'($urandom), 1'($urandom));
        step1(0, 0, 0, 0);
        step1(0, 0, 0, 0);
        @(negedge clk);
        #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain queue left %0d want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
